// File: rtl/mantissa_align_shifter.sv
// Pipelined logical right shifter for floating-point mantissa alignment.
// One pipeline stage per shift-amount bit, largest shift first. Bits shifted
// out below the round position are folded into a sticky bit. The sideband
// tag travels with its beat unchanged. All stages advance together whenever
// the output is empty or being consumed.
module mantissa_align_shifter #(
    parameter int unsigned W       = 11,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_mant,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_mant,
    output logic               out_guard,
    output logic               out_round,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    // Extended datapath: mantissa plus guard and round positions.
    localparam int unsigned EW   = W + 2;
    localparam int unsigned LAST = SHAMT_W - 1;

    logic [EW-1:0]      ext_q    [SHAMT_W];
    logic               sticky_q [SHAMT_W];
    logic [SHAMT_W-1:0] sh_q     [SHAMT_W];
    logic [TAG_W-1:0]   tag_q    [SHAMT_W];
    logic               vld_q    [SHAMT_W];

    logic en;

    // One conditional shift step; returns {sticky, ext}. A mask built from a
    // shifted all-ones vector covers every bit once the amount reaches EW.
    function automatic logic [EW:0] align_stage(input logic [EW-1:0] e,
                                                input logic          st,
                                                input logic          do_shift,
                                                input int unsigned   amt);
        logic [EW-1:0] mask;
        mask = ~({EW{1'b1}} << amt);
        if (do_shift) begin
            return {st | (|(e & mask)), e >> amt};
        end
        return {st, e};
    endfunction

    // Single global advance: the whole pipe moves unless the output is stalled.
    assign en       = out_ready | ~vld_q[LAST];
    assign in_ready = en;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int unsigned AMT = 32'd1 << (SHAMT_W - 1 - k);

        logic [EW-1:0]      ext_in;
        logic               st_in;
        logic [SHAMT_W-1:0] sh_in;
        logic [TAG_W-1:0]   tag_in;
        logic               vld_in;
        logic [EW-1:0]      ext_nxt;
        logic               st_nxt;

        if (k == 0) begin : g_first
            assign ext_in = {in_mant, 2'b00};
            assign st_in  = 1'b0;
            assign sh_in  = in_shamt;
            assign tag_in = in_tag;
            assign vld_in = in_valid;
        end else begin : g_rest
            assign ext_in = ext_q[k-1];
            assign st_in  = sticky_q[k-1];
            assign sh_in  = sh_q[k-1];
            assign tag_in = tag_q[k-1];
            assign vld_in = vld_q[k-1];
        end

        // The remaining shift bits are kept MSB-aligned, so each stage reads the top bit.
        assign {st_nxt, ext_nxt} = align_stage(ext_in, st_in, sh_in[SHAMT_W-1], AMT);

        // Stage register: loads on global advance, clears on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ext_q[k]    <= '0;
                sticky_q[k] <= 1'b0;
                sh_q[k]     <= '0;
                tag_q[k]    <= '0;
                vld_q[k]    <= 1'b0;
            end else if (en) begin
                ext_q[k]    <= ext_nxt;
                sticky_q[k] <= st_nxt;
                sh_q[k]     <= sh_in << 1;
                tag_q[k]    <= tag_in;
                vld_q[k]    <= vld_in;
            end
        end
    end

    // The final stage's leftover shift bits are all consumed.
    logic unused_sh;
    assign unused_sh = ^sh_q[LAST];

    assign out_valid  = vld_q[LAST];
    assign out_mant   = ext_q[LAST][EW-1:2];
    assign out_guard  = ext_q[LAST][1];
    assign out_round  = ext_q[LAST][0];
    assign out_sticky = sticky_q[LAST];
    assign out_tag    = tag_q[LAST];

endmodule
